// File: rtl/ysyx_25040109_inst_queue_if.sv
// Handshake bundle between the fetch memory side and the IDU for the instruction queue.
// The slave modport is the queue's side; the master modport is the side that drives the queue.
interface ysyx_25040109_inst_queue_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/ysyx_25040109_inst_queue.sv
// Instruction queue between memory and the IDU: a circular buffer with an optional
// combinational pass-through when empty, and a flush that drops everything stored.
module ysyx_25040109_inst_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 1
) (
    input logic                        clk,
    input logic                        rst,
    ysyx_25040109_inst_queue_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam bit BYP   = (BYPASS != 0);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic pass_thru;
    logic wr_en;
    logic rd_en;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    assign bus.in_ready  = !rst && !bus.flush && (!full || bus.out_ready);
    assign bus.out_valid = !rst && !bus.flush && (!empty || (BYP && bus.in_valid));
    assign bus.out_data  = (empty && BYP) ? bus.in_data : mem[rd_ptr];
    assign bus.count     = count;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // An empty queue that both accepts and delivers in one cycle never touches the array.
    assign pass_thru = empty && BYP && push && pop;
    assign wr_en     = push && !pass_thru;
    assign rd_en     = pop && !pass_thru;

    always_comb begin
        count_next = count;
        if (wr_en && !rd_en) begin
            count_next = count + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count_next;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is never cleared; count and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_ysyx_25040109_inst_queue.sv
// Directed bench for the instruction queue: one pass-through instance and one
// registered instance, checked against hand-computed values and a small queue model.
module tb_ysyx_25040109_inst_queue;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ysyx_25040109_inst_queue_if #(.DATA_W(32), .DEPTH(4)) ifb ();
    ysyx_25040109_inst_queue_if #(.DATA_W(32), .DEPTH(4)) ifr ();

    ysyx_25040109_inst_queue #(.DATA_W(32), .DEPTH(4), .BYPASS(1)) dut_byp (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    ysyx_25040109_inst_queue #(.DATA_W(32), .DEPTH(4), .BYPASS(0)) dut_reg (
        .clk (clk),
        .rst (rst),
        .bus (ifr)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] d, input logic rdy);
        ifb.in_valid  = v;
        ifb.in_data   = d;
        ifb.out_ready = rdy;
        #1;
    endtask

    logic [31:0] q[$];
    logic [31:0] tmp;
    logic [15:0] iv_pat;
    logic [15:0] or_pat;
    logic [31:0] d;
    logic        exp_ov;
    logic        exp_ir;
    logic [31:0] exp_od;

    initial begin
        rst = 1'b1;
        ifb.flush = 1'b0; ifb.in_valid = 1'b1; ifb.in_data = 32'h5; ifb.out_ready = 1'b1;
        ifr.flush = 1'b0; ifr.in_valid = 1'b0; ifr.in_data = 32'h0; ifr.out_ready = 1'b0;
        #2;
        chk("rst_in_ready", 32'(ifb.in_ready), 32'd0);
        chk("rst_out_valid", 32'(ifb.out_valid), 32'd0);
        tick;
        tick;
        chk("rst_count", 32'(ifb.count), 32'd0);
        rst = 1'b0;
        drv(1'b0, 32'h0, 1'b0);
        chk("post_rst_in_ready", 32'(ifb.in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(ifb.out_valid), 32'd0);

        // pass-through: each beat appears at the output in the cycle it is offered
        for (int i = 1; i <= 3; i++) begin
            d = 32'h11 * i;
            drv(1'b1, d, 1'b1);
            chk("byp_out_valid", 32'(ifb.out_valid), 32'd1);
            chk("byp_out_data", ifb.out_data, d);
            tick;
            chk("byp_count", 32'(ifb.count), 32'd0);
        end

        // fill to full with the consumer stalled
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 32'hA0 + i, 1'b0);
            chk("fill_in_ready", 32'(ifb.in_ready), 32'd1);
            chk("fill_head", ifb.out_data, 32'hA0);
            tick;
            chk("fill_count", 32'(ifb.count), 32'(i + 1));
        end
        drv(1'b1, 32'hA4, 1'b0);
        chk("full_in_ready", 32'(ifb.in_ready), 32'd0);
        chk("full_head", ifb.out_data, 32'hA0);
        drv(1'b1, 32'hA4, 1'b1);
        chk("full_pop_in_ready", 32'(ifb.in_ready), 32'd1);
        chk("full_pop_data", ifb.out_data, 32'hA0);
        tick;
        chk("full_pop_count", 32'(ifb.count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            drv(1'b0, 32'h0, 1'b1);
            chk("drain_valid", 32'(ifb.out_valid), 32'd1);
            chk("drain_data", ifb.out_data, 32'hA0 + i);
            tick;
        end
        drv(1'b0, 32'h0, 1'b1);
        chk("drain_count", 32'(ifb.count), 32'd0);
        chk("drain_valid_end", 32'(ifb.out_valid), 32'd0);

        // mixed push/pop traffic against a reference queue, wrapping the pointers
        iv_pat = 16'b0000_1110_1101_1111;
        or_pat = 16'b1111_0101_0010_1000;
        q.delete();
        for (int i = 0; i < 16; i++) begin
            d = 32'hC0 + i;
            drv(iv_pat[i], d, or_pat[i]);
            exp_ov = (q.size() > 0) || iv_pat[i];
            exp_od = (q.size() > 0) ? q[0] : d;
            exp_ir = (q.size() < 4) || or_pat[i];
            chk("wrap_out_valid", 32'(ifb.out_valid), 32'(exp_ov));
            if (exp_ov) chk("wrap_out_data", ifb.out_data, exp_od);
            chk("wrap_in_ready", 32'(ifb.in_ready), 32'(exp_ir));
            if (iv_pat[i] && exp_ir) q.push_back(d);
            if (exp_ov && or_pat[i]) tmp = q.pop_front();
            tick;
            chk("wrap_count", 32'(ifb.count), 32'(q.size()));
        end

        // flush with three entries stored and a beat on the input
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 32'hE1 + i, 1'b0);
            tick;
        end
        chk("pre_flush_count", 32'(ifb.count), 32'd3);
        ifb.flush = 1'b1;
        drv(1'b1, 32'h77, 1'b1);
        chk("flush_in_ready", 32'(ifb.in_ready), 32'd0);
        chk("flush_out_valid", 32'(ifb.out_valid), 32'd0);
        tick;
        ifb.flush = 1'b0;
        drv(1'b0, 32'h0, 1'b1);
        chk("post_flush_count", 32'(ifb.count), 32'd0);
        chk("post_flush_valid", 32'(ifb.out_valid), 32'd0);
        drv(1'b1, 32'h12, 1'b0);
        tick;
        drv(1'b0, 32'h0, 1'b1);
        chk("post_flush_head", ifb.out_data, 32'h12);
        tick;
        chk("post_flush_empty", 32'(ifb.count), 32'd0);

        // registered mode: one cycle to appear even with the consumer ready
        ifr.in_valid = 1'b1; ifr.in_data = 32'h55; ifr.out_ready = 1'b1;
        #1;
        chk("reg_first_valid", 32'(ifr.out_valid), 32'd0);
        chk("reg_in_ready", 32'(ifr.in_ready), 32'd1);
        tick;
        ifr.in_valid = 1'b0; ifr.in_data = 32'h0;
        #1;
        chk("reg_valid", 32'(ifr.out_valid), 32'd1);
        chk("reg_data", ifr.out_data, 32'h55);
        chk("reg_count", 32'(ifr.count), 32'd1);
        tick;
        chk("reg_count_after_pop", 32'(ifr.count), 32'd0);
        chk("reg_valid_after_pop", 32'(ifr.out_valid), 32'd0);

        // reset with two stored entries
        drv(1'b1, 32'hB1, 1'b0);
        tick;
        drv(1'b1, 32'hB2, 1'b0);
        tick;
        drv(1'b0, 32'h0, 1'b0);
        chk("pre_rst_count", 32'(ifb.count), 32'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(ifb.out_valid), 32'd0);
        chk("mid_rst_ready", 32'(ifb.in_ready), 32'd0);
        tick;
        rst = 1'b0;
        #1;
        chk("after_rst_count", 32'(ifb.count), 32'd0);
        chk("after_rst_valid", 32'(ifb.out_valid), 32'd0);
        drv(1'b1, 32'h99, 1'b0);
        tick;
        drv(1'b0, 32'h0, 1'b0);
        chk("fresh_valid", 32'(ifb.out_valid), 32'd1);
        chk("fresh_data", ifb.out_data, 32'h99);
        chk("fresh_count", 32'(ifb.count), 32'd1);
        drv(1'b0, 32'h0, 1'b1);
        tick;
        chk("fresh_drained", 32'(ifb.count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ysyx_25040109_inst_queue.md
YSYX_25040109_INST_QUEUE -- requirements
Module: ysyx_25040109_inst_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of storage entries; legal values are powers of two, 2..64.
REQ-003 SHALL have parameter BYPASS, default 1.
- 1: empty-queue pass-through.
- 0: every beat registered before it appears at the output.
REQ-004 SHALL define CNT_W = $clog2(DEPTH+1).
REQ-005 SHALL use one clock and a synchronous, active-high reset, with these ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  discard all stored and in-flight beats.
- in_valid  input  1  upstream (memory) beat valid.
- in_data  input  DATA_W  upstream payload.
- in_ready  output  1  queue accepts a beat this cycle.
- out_valid  output  1  beat available to downstream (IDU).
- out_data  output  DATA_W  downstream payload.
- out_ready  input  1  downstream accepts a beat.
- count  output  CNT_W  number of stored entries (bypassed beats not counted).

Function
REQ-006 SHALL define push = in_valid && in_ready and pop = out_valid && out_ready.
REQ-007 SHALL store entries in a DEPTH-entry array with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
REQ-008 SHALL drive in_ready = !flush && ((count < DEPTH) || out_ready); a full queue accepts a beat in the same cycle as a pop.
REQ-009 With count > 0, SHALL drive out_valid = !flush and out_data = array[rd_ptr].
REQ-010 With count == 0 and BYPASS=1, SHALL drive out_valid = in_valid && !flush and out_data = in_data, combinationally.
REQ-011 With count == 0 and BYPASS=0, SHALL drive out_valid = 0; out_data is don't-care.
REQ-012 With count == 0, BYPASS=1 and push && pop, SHALL hand the beat straight through, with no array write and no count change.
REQ-013 With count == 0, BYPASS=1, push and no pop, SHALL write the beat to array[wr_ptr]; count becomes 1 and the beat appears at out_data next cycle.
REQ-014 With count > 0, SHALL update state as follows:
- push only: write array[wr_ptr], wr_ptr+1, count+1.
- pop only: rd_ptr+1, count-1.
- push and pop: write and read, both pointers advance, count unchanged.
REQ-015 SHALL preserve order: beats leave in exactly the order accepted; none lost or duplicated absent flush/rst.
REQ-016 SHALL keep out_valid and out_data stable while out_valid && !out_ready, except under flush or rst.
REQ-017 When flush=1, SHALL on that edge set count, rd_ptr and wr_ptr to 0 and perform no push or pop; flush overrides in_valid/out_ready.
REQ-018 SHALL give latency in_valid -> out_valid of 0 cycles (empty, BYPASS=1) or 1 cycle (BYPASS=0, or queue non-empty with the beat at the head).
REQ-019 SHALL never overflow (count > DEPTH) or underflow; by REQ-008/REQ-009 a push is impossible when full without a pop, and a pop is impossible when empty (except bypass).

Reset
REQ-020 SHALL on rst=1 at a clock edge set count=0, rd_ptr=0 and wr_ptr=0, irrespective of other inputs; array contents need not be cleared.
REQ-021 SHALL hold out_valid=0, in_ready=0 and count=0 while rst=1; after rst deasserts, in_ready=1 and out_valid follows REQ-010/011.
REQ-022 SHALL discard all stored beats when rst is asserted mid-operation, with no beat emitted afterward that was accepted before the reset.

Verification
REQ-023 SHALL cover bypass, BYPASS=1, DEPTH=4: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 same cycles, count stays 0.
REQ-024 SHALL cover fill/full, DEPTH=4: out_ready=0, push 0xA0..0xA4 -> 0xA0..0xA3 accepted, count=4, in_ready=0 at 0xA4. Then out_ready=1 -> 0xA4 accepted in the same cycle as 0xA0 leaves, count stays 4, drain order 0xA0..0xA4.
REQ-025 SHALL cover wrap-around: 10 random push/pop cycles over DEPTH=4 with pointers wrapping twice -> output sequence equals input sequence.
REQ-026 SHALL cover registered mode, BYPASS=0: push 0x55 into an empty queue with out_ready=1 -> out_valid=0 that cycle; next cycle out_valid=1, out_data=0x55, count=1 -> 0 after pop.
REQ-027 SHALL cover flush with 3 entries stored plus in_valid=1 with 0x77: assert flush -> in_ready=0 and out_valid=0 that cycle, next cycle count=0, and 0x77 never appears.
REQ-028 SHALL cover reset mid-stream: rst with count=2 -> count=0, out_valid=0 next cycle, and a fresh push of 0x99 is the next beat out.
